// File: rtl/vgademo_pkg.sv
// Shared constants and types for the projection datapath stages.
package vgademo_pkg;

   localparam int A_W_DEF   = 32'sd10;
   localparam int B_W_DEF   = 32'sd16;
   localparam int OUT_W_DEF = 32'sd10;
   localparam int SHIFT_DEF = 32'sd16;

   // Reciprocal fixed-point scale: 1.0 is represented as 2^16.
   localparam int RECIP_ONE = 32'sd65536;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift (floor) followed by signed saturation to OUT_W bits.
module sat_shift #(
   parameter int IN_W  = 32'sd26,
   parameter int SHIFT = 32'sd16,
   parameter int OUT_W = 32'sd10
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0] MAX_V = IN_W'((32'sd1 <<< (OUT_W - 32'sd1)) - 32'sd1);
   localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(32'sd1 <<< (OUT_W - 32'sd1)));

   logic signed [IN_W-1:0] shifted_s;

   // Floor-shift then clamp into the signed output range.
   always_comb begin
      shifted_s = $signed(din) >>> SHIFT;
      if (shifted_s > MAX_V) begin
         dout = MAX_V[OUT_W-1:0];
      end else if (shifted_s < MIN_V) begin
         dout = MIN_V[OUT_W-1:0];
      end else begin
         dout = shifted_s[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/recip_mul16.sv
// Radix-2 shift-add multiplier: signed operand times unsigned reciprocal,
// fixed B_W-cycle latency, saturated scaled result.
module recip_mul16
   import vgademo_pkg::*;
#(
   parameter int A_W   = A_W_DEF,
   parameter int B_W   = B_W_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     recip,
   output logic               busy,
   output logic               done,
   output logic [A_W+B_W-1:0] prod,
   output logic [OUT_W-1:0]   result
);

   localparam int P_W   = A_W + B_W;
   localparam int CNT_W = $clog2(B_W);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [P_W-1:0]   mcand_r;
   logic [B_W-1:0]   mplier_r;
   logic [P_W-1:0]   acc_r;
   logic [P_W-1:0]   prod_r;
   logic             busy_r;
   logic             done_r;
   logic [P_W-1:0]   acc_next_s;

   // Conditional add of the multiplicand for the current multiplier bit.
   always_comb begin
      acc_next_s = acc_r;
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // Control FSM and datapath; start always wins over an operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         prod_r   <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else if (start) begin
         state_r  <= RUN;
         cnt_r    <= '0;
         mcand_r  <= {{B_W{a[A_W-1]}}, a};
         mplier_r <= recip;
         acc_r    <= '0;
         busy_r   <= 1'b1;
         done_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
            RUN: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(B_W - 1)) begin
                  prod_r  <= acc_next_s;
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign prod = prod_r;

   sat_shift #(
      .IN_W  (P_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_sat_shift (
      .din  (prod_r),
      .dout (result)
   );

endmodule

// File: doc/recip_mul16.md
# recip_mul16

Sequential shift-add multiplier that applies a 16-bit unsigned fixed-point reciprocal to a signed screen-space operand. It is the consumer end of the reciprocal path: the reciprocal unit produces 65536/d, and this block forms a × (65536/d) and scales it back by >> SHIFT, giving the perspective divide a/d. It has one radix-2 iteration per cycle and fixed latency, so raster timing stays deterministic. It sits between the reciprocal unit and the per-pixel projection registers.

## Interface
- A_W, default 10: width of signed operand `a`.
- B_W, default 16: width of unsigned reciprocal `recip`. This is also the iteration count.
- SHIFT, default 16: arithmetic right shift applied to the full product to form `result`.
- OUT_W, default 10: width of signed saturated `result`.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  load operands and begin. Takes precedence over any operation in flight.
- a  in  A_W  signed multiplicand; sampled only on a start edge.
- recip  in  B_W  unsigned multiplier (fixed-point, 1.0 = 2^16); sampled only on a start edge.
- busy  out  1  high while iterations remain.
- done  out  1  one-cycle pulse when `prod` and `result` become valid.
- prod  out  A_W+B_W  signed full product a×recip, registered.
- result  out  OUT_W  signed; equals sat(prod >>> SHIFT), combinational from `prod`.

## Operation
- States:
  - IDLE (busy=0).
  - RUN (busy=1, iteration counter i = 0..B_W-1).
- start in any state:
  - Load the multiplicand register with `a` sign-extended to A_W+B_W.
  - Load the multiplier shift register with `recip`.
  - Clear the accumulator. Set i=0 and enter RUN. Clear done.
- Each RUN cycle:
  - If the multiplier LSB is 1, add the multiplicand register to the accumulator, modulo 2^(A_W+B_W).
  - Shift the multiplicand left by 1 and the multiplier right by 1. Increment i.
- After iteration i = B_W-1:
  - Copy the accumulator to `prod` and go to IDLE.
  - Assert done for exactly one cycle.
- Arithmetic:
  - Two's-complement accumulation is exact for signed × unsigned, so no correction step is needed.
  - The shift is arithmetic (floor toward −∞).
  - Saturation clamps to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- No early termination: latency is fixed even when the remaining multiplier bits are zero.
- `prod` and `result` hold their last value until the next completion. They do not change during RUN.

## Timing
- Reset values: busy=0, done=0, prod=0, result=0; state IDLE, i=0.
- Reset asserted mid-operation aborts it immediately. No done pulse follows, and `prod` reads 0.
- start sampled at edge E0 → busy=1 after E0. Iterations occur on E1..E16 (B_W=16).
- After E16: done=1, busy=0, and `prod`/`result` are valid. After E17, done=0.
- Start-to-done latency is B_W cycles. Throughput is one result per B_W cycles.
- A start in the same cycle done is high is accepted: done falls, busy rises, and the previous `prod` is held.
- A start during RUN discards the in-flight operation. Exactly one done pulse follows, B_W cycles after the last start.
- start held high for several cycles reloads every cycle. The count begins from the final start edge.

## Structure
- Shared package (`vgademo_pkg`): A_W/B_W/OUT_W defaults, the reciprocal fixed-point constant RECIP_ONE = 2^16, and the state enum {IDLE, RUN}.
- One sub-module, `sat_shift`: combinational arithmetic right shift by SHIFT plus signed saturation to OUT_W. It is reused by other projection stages.
- Counter width is $clog2(B_W).

## Test plan
- a=257, recip=0x8000, defaults: done exactly 16 cycles after start; prod=8421376, result=128; busy high for exactly 16 cycles.
- a=−300, recip=0xFFFF: prod=−19660500, result=−300 (floor, not truncate toward zero).
- SHIFT=8 with recip=0x0400: a=511 → prod=523264, result=511 (saturated); a=−512 → prod=−524288, result=−512.
- Restart: start(a=3, recip=5); at iteration 5, start(a=7, recip=9). Single done 16 cycles after the second start; prod=63.
- Reset mid-operation at iteration 8: busy=0, done=0, prod=0 immediately (asynchronous); no done pulse in the following 32 cycles.
- Back-to-back: new start coincident with done, with a=−1, recip=1. First result stays held through the second RUN; second done gives prod=−1 and result=−1.
